shift_sequencer: RTL and testbench



---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_sequencer.sv | 105 ++++++++++
 tb/tb_shift_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift-register sequencer.
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic DIR_LSB     = 1'b0;
   localparam logic DIR_MSB     = 1'b1;
   localparam int   SHIFT_CNT_W = 3;

endpackage

// File: rtl/shift_sequencer.sv
// Control stage that loads a 4-bit load/shift register and clocks it out as a
// qualified serial stream (parallel-to-serial), one word per SHIFTS+3 cycles.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int   SHIFTS = 4,
   parameter logic FILL   = 1'b0
) (
   input  logic       C,
   input  logic       nR,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   input  logic       in_dir,
   input  logic       flush,
   output logic       sr_L,
   output logic       sr_RTL,
   output logic [3:0] sr_D,
   input  logic [3:0] sr_Q,
   output logic       ser_out,
   output logic       ser_valid,
   output logic       done,
   output logic       busy
);

   localparam logic [SHIFT_CNT_W-1:0] CNT_LAST = SHIFT_CNT_W'(SHIFTS - 1);

   state_t                 state, state_d;
   logic [3:0]             word_q;
   logic                   dir_q;
   logic [SHIFT_CNT_W-1:0] cnt;
   logic                   accept;

   // Middle register bits never leave the register toward the stream.
   logic unused_sr_q;
   assign unused_sr_q = ^sr_Q[2:1];

   assign accept = (state == IDLE) && in_valid && !flush;

   always_ff @(posedge C or negedge nR) begin
      if (!nR) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state)
            IDLE:    if (in_valid) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge C or negedge nR) begin
      if (!nR) begin
         word_q <= '0;
         dir_q  <= DIR_LSB;
         cnt    <= '0;
      end else begin
         if (accept) begin
            word_q <= in_data;
            dir_q  <= in_dir;
         end
         if (state == LOAD)       cnt <= '0;
         else if (state == SHIFT) cnt <= cnt + SHIFT_CNT_W'(1);
      end
   end

   // ser_out is the only output that looks at a live input (the register feedback).
   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      sr_L      = 1'b0;
      sr_RTL    = dir_q;
      sr_D      = '0;
      ser_valid = 1'b0;
      ser_out   = 1'b0;
      done      = 1'b0;
      case (state)
         LOAD: begin
            sr_L = 1'b1;
            sr_D = word_q;
         end
         SHIFT: begin
            ser_valid = 1'b1;
            if (dir_q == DIR_MSB) begin
               sr_D    = {3'b000, FILL};
               ser_out = sr_Q[3];
            end else begin
               sr_D    = {FILL, 3'b000};
               ser_out = sr_Q[0];
            end
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench: three sequencers (SHIFTS/FILL = 4/0, 4/1, 6/0) each driving a 4-bit
// load/shift register, checked cycle by cycle against a word-level model.
module tb_shift_sequencer;

   logic       C = 1'b0;
   logic       nR;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_dir;
   logic       flush;

   logic       in_ready  [3];
   logic       sr_l      [3];
   logic       sr_rtl    [3];
   logic [3:0] sr_d      [3];
   logic [3:0] sr_q      [3];
   logic       ser_out   [3];
   logic       ser_valid [3];
   logic       done      [3];
   logic       busy      [3];

   int checks = 0;
   int errors = 0;

   always #5 C = ~C;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [3:0] q = 4'b0000;

      // The 4-bit load/shift register this block drives.
      always_ff @(posedge C) begin
         if (sr_l[g])        q <= sr_d[g];
         else if (sr_rtl[g]) q <= {q[2:0], sr_d[g][0]};
         else                q <= {sr_d[g][3], q[3:1]};
      end
      assign sr_q[g] = q;

      shift_sequencer #(
         .SHIFTS ((g == 2) ? 6 : 4),
         .FILL   ((g == 1) ? 1'b1 : 1'b0)
      ) u_dut (
         .C         (C),
         .nR        (nR),
         .in_valid  (in_valid),
         .in_ready  (in_ready[g]),
         .in_data   (in_data),
         .in_dir    (in_dir),
         .flush     (flush),
         .sr_L      (sr_l[g]),
         .sr_RTL    (sr_rtl[g]),
         .sr_D      (sr_d[g]),
         .sr_Q      (sr_q[g]),
         .ser_out   (ser_out[g]),
         .ser_valid (ser_valid[g]),
         .done      (done[g]),
         .busy      (busy[g])
      );
   end

   function automatic int sh(input int i);
      return (i == 2) ? 6 : 4;
   endfunction

   function automatic logic fl(input int i);
      return (i == 1) ? 1'b1 : 1'b0;
   endfunction

   // k-th bit on the serial stream: data bits in shift order, then fill bits.
   function automatic logic ref_bit(input logic [3:0] w, input logic d, input int k, input logic f);
      if (k >= 4) return f;
      return d ? w[3 - k] : w[k];
   endfunction

   // Register contents after s shifts of word w.
   function automatic logic [3:0] ref_q(input logic [3:0] w, input logic d, input int s, input logic f);
      int v;
      if (d) v = (int'(w) << s) | (f ? ((1 << s) - 1) : 0);
      else   v = (int'(w) >> s) | (f ? ((s >= 4) ? 15 : (15 << (4 - s))) : 0);
      return 4'(v & 15);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected outputs t cycles after the accept edge.
   task automatic check_cycle(input int t, input logic [3:0] w, input logic d);
      for (int i = 0; i < 3; i++) begin
         int   s;
         logic vld;
         s   = sh(i);
         vld = (t >= 2) && (t <= 1 + s);
         chk($sformatf("d%0d_t%0d_ser_valid", i, t), 8'(ser_valid[i]), 8'(vld));
         chk($sformatf("d%0d_t%0d_ser_out", i, t), 8'(ser_out[i]),
             8'(vld ? ref_bit(w, d, t - 2, fl(i)) : 1'b0));
         chk($sformatf("d%0d_t%0d_done", i, t), 8'(done[i]), 8'(t == 2 + s));
         chk($sformatf("d%0d_t%0d_busy", i, t), 8'(busy[i]), 8'((t >= 1) && (t <= 2 + s)));
         chk($sformatf("d%0d_t%0d_in_ready", i, t), 8'(in_ready[i]), 8'(!((t >= 1) && (t <= 2 + s))));
         chk($sformatf("d%0d_t%0d_sr_L", i, t), 8'(sr_l[i]), 8'(t == 1));
         if (t >= 1 && t <= 2 + s)
            chk($sformatf("d%0d_t%0d_sr_RTL", i, t), 8'(sr_rtl[i]), 8'(d));
         if (t == 2 + s)
            chk($sformatf("d%0d_final_sr_Q", i), 8'(sr_q[i]), 8'(ref_q(w, d, s, fl(i))));
      end
   endtask

   task automatic run_word(input logic [3:0] w, input logic d);
      @(negedge C);
      in_valid = 1'b1;
      in_data  = w;
      in_dir   = d;
      for (int i = 0; i < 3; i++)
         chk($sformatf("d%0d_accept_ready", i), 8'(in_ready[i]), 8'd1);
      for (int t = 1; t <= 9; t++) begin
         @(negedge C);
         if (t == 1) begin
            in_valid = 1'b0;
            in_data  = 4'($urandom);
            in_dir   = 1'($urandom);
         end
         check_cycle(t, w, d);
      end
   endtask

   initial begin
      nR       = 1'b0;
      in_valid = 1'b0;
      in_data  = 4'b0000;
      in_dir   = 1'b0;
      flush    = 1'b0;
      #12;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("d%0d_rst_in_ready", i), 8'(in_ready[i]), 8'd1);
         chk($sformatf("d%0d_rst_busy", i), 8'(busy[i]), 8'd0);
         chk($sformatf("d%0d_rst_sr_L", i), 8'(sr_l[i]), 8'd0);
         chk($sformatf("d%0d_rst_sr_RTL", i), 8'(sr_rtl[i]), 8'd0);
         chk($sformatf("d%0d_rst_sr_D", i), 8'(sr_d[i]), 8'd0);
         chk($sformatf("d%0d_rst_ser_valid", i), 8'(ser_valid[i]), 8'd0);
         chk($sformatf("d%0d_rst_done", i), 8'(done[i]), 8'd0);
      end
      @(negedge C);
      nR = 1'b1;

      run_word(4'b1011, 1'b1);
      run_word(4'b1011, 1'b0);
      run_word(4'b1000, 1'b1);
      for (int k = 0; k < 6; k++)
         run_word(4'($urandom), 1'($urandom));

      // Abort during the second shift cycle, then flush competing with a request.
      @(negedge C);
      in_valid = 1'b1; in_data = 4'b1101; in_dir = 1'b0;
      @(negedge C);
      in_valid = 1'b0;
      @(negedge C);
      @(negedge C);
      for (int i = 0; i < 3; i++)
         chk($sformatf("d%0d_flush_pre_valid", i), 8'(ser_valid[i]), 8'd1);
      flush = 1'b1;
      @(negedge C);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("d%0d_flush_busy", i), 8'(busy[i]), 8'd0);
         chk($sformatf("d%0d_flush_ready", i), 8'(in_ready[i]), 8'd1);
         chk($sformatf("d%0d_flush_done", i), 8'(done[i]), 8'd0);
      end
      in_valid = 1'b1;
      @(negedge C);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("d%0d_flush_noacc_busy", i), 8'(busy[i]), 8'd0);
         chk($sformatf("d%0d_flush_noacc_ready", i), 8'(in_ready[i]), 8'd1);
      end
      flush = 1'b0; in_valid = 1'b0;
      for (int t = 0; t < 8; t++) begin
         @(negedge C);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_post_flush_done_%0d", i, t), 8'(done[i]), 8'd0);
            chk($sformatf("d%0d_post_flush_busy_%0d", i, t), 8'(busy[i]), 8'd0);
         end
      end

      // Reset in the middle of a word.
      @(negedge C);
      in_valid = 1'b1; in_data = 4'b0101; in_dir = 1'b1;
      @(negedge C);
      in_valid = 1'b0;
      @(negedge C);
      @(negedge C);
      nR = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("d%0d_midrst_busy", i), 8'(busy[i]), 8'd0);
         chk($sformatf("d%0d_midrst_ready", i), 8'(in_ready[i]), 8'd1);
         chk($sformatf("d%0d_midrst_sr_L", i), 8'(sr_l[i]), 8'd0);
         chk($sformatf("d%0d_midrst_ser_valid", i), 8'(ser_valid[i]), 8'd0);
         chk($sformatf("d%0d_midrst_sr_RTL", i), 8'(sr_rtl[i]), 8'd0);
         chk($sformatf("d%0d_midrst_sr_D", i), 8'(sr_d[i]), 8'd0);
      end
      @(negedge C);
      nR = 1'b1;
      run_word(4'b1110, 1'b1);

      // in_valid held high: acceptance every SHIFTS+3 cycles.
      @(negedge C);
      in_valid = 1'b1; in_data = 4'b0110; in_dir = 1'b1;
      for (int t = 0; t < 22; t++) begin
         for (int i = 0; i < 3; i++)
            chk($sformatf("d%0d_held_ready_t%0d", i, t), 8'(in_ready[i]), 8'((t % (sh(i) + 3)) == 0));
         @(negedge C);
      end
      in_valid = 1'b0;
      repeat (12) @(negedge C);
      for (int i = 0; i < 3; i++)
         chk($sformatf("d%0d_drained_busy", i), 8'(busy[i]), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
